// File: rtl/mor1kx_ibus_responder.sv
// rtl/mor1kx_ibus_responder.sv - instruction-bus target with word memory and programmable response latency
//
// Answers a level-held fetch request (ibus_req_i/ibus_adr_i) with a one-cycle
// ack or err pulse after WAIT_STATES extra cycles. Instruction words live in
// an internal memory that is filled through an independent load port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ibus_req_i/ibus_adr_i fetch request level and byte address
//   ibus_ack_o/ibus_err_o one-cycle response pulses (never both high)
//   ibus_dat_o            instruction word, held between responses
//   extra_wait_i          freezes the wait counter while high
//   load_we_i/adr/dat     memory write port (word index)

module mor1kx_ibus_responder #(
    parameter int                OPTION_OPERAND_WIDTH = 32,
    parameter int                MEM_DEPTH            = 1024,
    parameter longint unsigned   MEM_BASE             = 0,
    parameter int                WAIT_STATES          = 1,
    parameter logic [31:0]       OPTION_RESET_INSN    = 32'h15000000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ibus_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_i,
    output logic                            ibus_ack_o,
    output logic                            ibus_err_o,
    output logic [31:0]                     ibus_dat_o,
    input  logic                            extra_wait_i,
    input  logic                            load_we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]    load_adr_i,
    input  logic [31:0]                     load_dat_i
);

    localparam int          AW       = $clog2(MEM_DEPTH);
    localparam logic [3:0]  CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [63:0] LIMIT_LO = 64'(MEM_BASE);
    localparam logic [63:0] LIMIT_HI = LIMIT_LO + 64'(MEM_DEPTH) * 64'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0]                     mem [MEM_DEPTH];
    state_t                          state, state_nxt;
    logic [3:0]                      cnt, cnt_nxt;
    logic [OPTION_OPERAND_WIDTH-1:0] adr_r, adr_nxt;
    logic                            ack_nxt, err_nxt, go_resp;
    logic [31:0]                     dat_nxt;

    // A zero-wait response is decided in IDLE, before adr_r has captured the
    // request, so the live address is used there. In WAIT the two are equal
    // whenever the count can complete (an address change takes priority).
    logic [OPTION_OPERAND_WIDTH-1:0] resp_adr;
    logic [63:0]                     resp_adr_ext;
    logic                            resp_bad;
    logic [AW-1:0]                   resp_idx;

    assign resp_adr     = (state == IDLE) ? ibus_adr_i : adr_r;
    assign resp_adr_ext = 64'(resp_adr);
    assign resp_bad     = (resp_adr[1:0] != 2'b00) ||
                          (resp_adr_ext < LIMIT_LO) ||
                          (resp_adr_ext >= LIMIT_HI);
    // MEM_BASE is aligned to the memory size, so the low word-address bits
    // are already the offset from the base.
    assign resp_idx     = resp_adr[AW+1:2];

    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_adr_i] <= load_dat_i;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        adr_nxt   = adr_r;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        dat_nxt   = ibus_dat_o;
        go_resp   = 1'b0;

        case (state)
            IDLE: begin
                if (ibus_req_i) begin
                    adr_nxt = ibus_adr_i;
                    if (WAIT_STATES == 0) begin
                        go_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!ibus_req_i) begin
                    state_nxt = IDLE;
                end else if (ibus_adr_i != adr_r) begin
                    adr_nxt = ibus_adr_i;
                    cnt_nxt = CNT_LOAD;
                end else if (!extra_wait_i) begin
                    if (cnt == 4'd0) begin
                        go_resp = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end
            RESP: begin
                // Forced IDLE cycle gives the fetch unit time to move the address.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Memory is read here, on the edge entering RESP; a load to the same
        // word on that edge lands after the read, so old data is returned.
        if (go_resp) begin
            state_nxt = RESP;
            if (resp_bad) begin
                err_nxt = 1'b1;
                dat_nxt = OPTION_RESET_INSN;
            end else begin
                ack_nxt = 1'b1;
                dat_nxt = mem[resp_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            adr_r      <= '0;
            ibus_ack_o <= 1'b0;
            ibus_err_o <= 1'b0;
            ibus_dat_o <= OPTION_RESET_INSN;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            adr_r      <= adr_nxt;
            ibus_ack_o <= ack_nxt;
            ibus_err_o <= err_nxt;
            ibus_dat_o <= dat_nxt;
        end
    end

endmodule

// File: tb/tb_mor1kx_ibus_responder.sv
// tb/tb_mor1kx_ibus_responder.sv - self-checking bench for mor1kx_ibus_responder

module tb_mor1kx_ibus_responder;

    localparam int          NI    = 5;
    localparam int          DEPTH = 16;
    localparam logic [31:0] RST   = 32'h15000000;

    // Instances 0..3 have WAIT_STATES 0..3 at base 0; instance 4 has one wait
    // state and its memory at byte 0x40.
    function automatic int ws_of(input int k);
        return (k == 4) ? 1 : k;
    endfunction

    function automatic longint unsigned base_of(input int k);
        return (k == 4) ? 64 : 0;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] adr;
    logic        extra;
    logic        load_we;
    logic [3:0]  load_adr;
    logic [31:0] load_dat;

    logic        ack [NI];
    logic        err [NI];
    logic [31:0] dat [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mor1kx_ibus_responder #(
            .OPTION_OPERAND_WIDTH (32),
            .MEM_DEPTH            (DEPTH),
            .MEM_BASE             ((g == 4) ? 64 : 0),
            .WAIT_STATES          ((g == 4) ? 1 : g),
            .OPTION_RESET_INSN    (RST)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .ibus_req_i   (req),
            .ibus_adr_i   (adr),
            .ibus_ack_o   (ack[g]),
            .ibus_err_o   (err[g]),
            .ibus_dat_o   (dat[g]),
            .extra_wait_i (extra),
            .load_we_i    (load_we),
            .load_adr_i   (load_adr),
            .load_dat_i   (load_dat)
        );
    end

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit compare_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: each pending fetch is a deadline (edge index of
    // the response) that freezes push out and address changes re-arm.
    logic [31:0] mmem [DEPTH];
    int          phase [NI];   // 0 idle, 1 pending, 2 responding
    int          dl    [NI];
    logic [31:0] ma    [NI];
    logic        m_ack [NI];
    logic        m_err [NI];
    logic [31:0] m_dat [NI];
    int          mcyc;

    function automatic bit exp_bad(input int k, input logic [31:0] a);
        longint unsigned aa;
        aa = a;
        return (a[1:0] != 2'b00) || (aa < base_of(k)) || (aa >= base_of(k) + DEPTH * 4);
    endfunction

    function automatic logic [31:0] exp_word(input int k, input logic [31:0] a);
        if (exp_bad(k, a)) return RST;
        return mmem[int'((longint'(a) - longint'(base_of(k))) / 4)];
    endfunction

    always @(posedge clk) begin
        if (load_we) mmem[load_adr] <= load_dat;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcyc <= 0;
            for (int k = 0; k < NI; k++) begin
                phase[k] <= 0;
                dl[k]    <= 0;
                ma[k]    <= '0;
                m_ack[k] <= 1'b0;
                m_err[k] <= 1'b0;
                m_dat[k] <= RST;
            end
        end else begin
            mcyc <= mcyc + 1;
            for (int k = 0; k < NI; k++) begin
                m_ack[k] <= 1'b0;
                m_err[k] <= 1'b0;
                case (phase[k])
                    0: if (req) begin
                        ma[k] <= adr;
                        if (ws_of(k) == 0) begin
                            m_err[k] <= exp_bad(k, adr);
                            m_ack[k] <= !exp_bad(k, adr);
                            m_dat[k] <= exp_word(k, adr);
                            phase[k] <= 2;
                        end else begin
                            dl[k]    <= mcyc + ws_of(k);
                            phase[k] <= 1;
                        end
                    end
                    1: if (!req) begin
                        phase[k] <= 0;
                    end else if (adr != ma[k]) begin
                        ma[k] <= adr;
                        dl[k] <= mcyc + ws_of(k);
                    end else if (extra) begin
                        dl[k] <= dl[k] + 1;
                    end else if (mcyc == dl[k]) begin
                        m_err[k] <= exp_bad(k, ma[k]);
                        m_ack[k] <= !exp_bad(k, ma[k]);
                        m_dat[k] <= exp_word(k, ma[k]);
                        phase[k] <= 2;
                    end
                    default: phase[k] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (compare_on) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("model ack[%0d] cyc %0d", k, cyc), {31'd0, ack[k]}, {31'd0, m_ack[k]});
                check($sformatf("model err[%0d] cyc %0d", k, cyc), {31'd0, err[k]}, {31'd0, m_err[k]});
                check($sformatf("model dat[%0d] cyc %0d", k, cyc), dat[k], m_dat[k]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req   = 1'b0;
        extra = 1'b0;
        tick(6);
    endtask

    // Returns edges from the drive point t0 to the first pulse, -1 on timeout.
    task automatic wait_pulse(input int k, input int t0, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (ack[k] || err[k]) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    int t0, lat, pulses;

    initial begin
        rst_n = 1'b0; req = 1'b0; adr = '0; extra = 1'b0;
        load_we = 1'b0; load_adr = '0; load_dat = '0;
        tick(2);
        compare_on = 1'b1;
        check("reset ack", {31'd0, ack[1]}, 32'd0);
        check("reset err", {31'd0, err[1]}, 32'd0);
        check("reset dat", dat[3], RST);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            load_we = 1'b1; load_adr = 4'(i); load_dat = 32'hA0 + 32'(i);
            tick(1);
        end
        load_we = 1'b0;
        tick(2);

        // zero wait states
        t0 = cyc; req = 1'b1; adr = 32'h0;
        wait_pulse(0, t0, 10, lat);
        check("zero-wait latency", 32'(lat), 32'd1);
        check("zero-wait dat", dat[0], 32'hA0);
        idle();

        // back-to-back fetch, address steps after each ack
        t0 = cyc; req = 1'b1; adr = 32'h0;
        for (int j = 0; j < 4; j++) begin
            wait_pulse(1, t0, 10, lat);
            check($sformatf("b2b spacing %0d", j), 32'(lat), (j == 0) ? 32'd2 : 32'd3);
            check($sformatf("b2b dat %0d", j), dat[1], 32'hA0 + 32'(j));
            t0 = cyc; adr = adr + 32'd4;
        end
        idle();

        // errors
        t0 = cyc; req = 1'b1; adr = 32'd64;
        wait_pulse(1, t0, 10, lat);
        check("oob latency", 32'(lat), 32'd2);
        check("oob err", {31'd0, err[1]}, 32'd1);
        check("oob ack", {31'd0, ack[1]}, 32'd0);
        check("oob dat", dat[1], RST);
        idle();
        t0 = cyc; req = 1'b1; adr = 32'h2;
        wait_pulse(1, t0, 10, lat);
        check("misaligned err", {31'd0, err[1]}, 32'd1);
        idle();
        t0 = cyc; req = 1'b1; adr = 32'h44;
        wait_pulse(4, t0, 10, lat);
        check("based ack", {31'd0, ack[4]}, 32'd1);
        check("based dat", dat[4], 32'hA1);
        idle();
        t0 = cyc; req = 1'b1; adr = 32'h0;
        wait_pulse(4, t0, 10, lat);
        check("below base err", {31'd0, err[4]}, 32'd1);
        idle();

        // request dropped in WAIT, then a fresh fetch
        req = 1'b1; adr = 32'h4;
        tick(2);
        req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (ack[3] || err[3]) pulses++;
        end
        check("abort no pulse", 32'(pulses), 32'd0);
        t0 = cyc; req = 1'b1; adr = 32'h4;
        wait_pulse(3, t0, 12, lat);
        check("after abort latency", 32'(lat), 32'd4);
        check("after abort dat", dat[3], 32'hA1);
        idle();

        // address change in WAIT restarts the count
        req = 1'b1; adr = 32'h0;
        tick(1);
        t0 = cyc; adr = 32'h8;
        wait_pulse(3, t0, 12, lat);
        req = 1'b0;
        check("restart latency", 32'(lat), 32'd4);
        check("restart dat", dat[3], 32'hA2);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (ack[3] || err[3]) pulses++;
        end
        check("restart single pulse", 32'(pulses), 32'd0);
        idle();

        // freeze for three WAIT cycles
        t0 = cyc; req = 1'b1; adr = 32'hC;
        tick(1);
        extra = 1'b1;
        tick(3);
        extra = 1'b0;
        wait_pulse(2, t0, 10, lat);
        check("freeze latency", 32'(lat), 32'd6);
        check("freeze dat", dat[2], 32'hA3);
        idle();

        // load collision on the edge entering RESP
        t0 = cyc; req = 1'b1; adr = 32'h0;
        tick(1);
        load_we = 1'b1; load_adr = 4'd0; load_dat = 32'hDEAD;
        wait_pulse(1, t0, 10, lat);
        load_we = 1'b0;
        check("collision latency", 32'(lat), 32'd2);
        check("collision old data", dat[1], 32'hA0);
        idle();
        t0 = cyc; req = 1'b1; adr = 32'h0;
        wait_pulse(1, t0, 10, lat);
        check("after collision dat", dat[1], 32'hDEAD);
        idle();

        // asynchronous reset mid-access
        req = 1'b1; adr = 32'h4;
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset ack3", {31'd0, ack[3]}, 32'd0);
        check("async reset err3", {31'd0, err[3]}, 32'd0);
        check("async reset dat3", dat[3], RST);
        check("async reset ack0", {31'd0, ack[0]}, 32'd0);
        check("async reset dat0", dat[0], RST);
        tick(1);
        rst_n = 1'b1;
        t0 = cyc;
        wait_pulse(1, t0, 10, lat);
        check("post-reset latency", 32'(lat), 32'd2);
        check("post-reset dat", dat[1], 32'hA1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1);
    end

endmodule

// File: doc/mor1kx_ibus_responder.md
# mor1kx_ibus_responder

Instruction-bus target that answers the fetch unit's level-held `ibus_req` and `ibus_adr` with single-cycle `ibus_ack`/`ibus_err` pulses and instruction data. It holds a word-addressed instruction memory, loaded through a side write port, and produces a programmable, deterministic response latency. It serves as the on-chip boot/tightly-coupled instruction store and as the bus model for fetch-unit verification.

## Interface
Parameters:
- `OPTION_OPERAND_WIDTH`, 32: address width.
- `MEM_DEPTH`, 1024: memory size in 32-bit words; power of two.
- `MEM_BASE`, 0: byte address of word 0; aligned to `MEM_DEPTH*4`.
- `WAIT_STATES`, 1: extra response cycles, 0..15.
- `OPTION_RESET_INSN`, 32'h15000000: l.nop; reset and error value of `ibus_dat_o`.

Ports:
- `clk`  in  1: clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ibus_req_i`  in  1: fetch request, level.
- `ibus_adr_i`  in  OPTION_OPERAND_WIDTH: fetch byte address.
- `ibus_ack_o`  out  1: one-cycle pulse, data valid.
- `ibus_err_o`  out  1: one-cycle pulse, access error.
- `ibus_dat_o`  out  32: instruction word.
- `extra_wait_i`  in  1: freezes the wait counter; used for backpressure injection.
- `load_we_i`  in  1: memory write strobe.
- `load_adr_i`  in  log2(MEM_DEPTH): word index.
- `load_dat_i`  in  32: write data.

## Operation
- FSM has three states: IDLE, WAIT and RESP. There is a 4-bit down-counter `cnt` and an address latch `adr_r`.
- **IDLE:**
  - If `ibus_req_i` is high, latch `adr_r <= ibus_adr_i`.
  - If `WAIT_STATES==0`, go to RESP. Otherwise go to WAIT with `cnt <= WAIT_STATES-1`.
  - If `ibus_req_i` is low, stay in IDLE.
- **WAIT:**
  - **Request dropped:** if `ibus_req_i` is low, go to IDLE. No ack or err is issued.
  - **Address changed:** if `ibus_req_i` is high and `ibus_adr_i != adr_r`, restart in place: latch the new address, reload `cnt <= WAIT_STATES-1` and stay in WAIT.
  - **Frozen:** if `extra_wait_i` is high, hold `cnt`.
  - **Count done:** if `cnt==0`, go to RESP.
  - **Otherwise:** decrement `cnt`.
  - Priority order: request dropped, address changed, frozen, count done, decrement.
- **RESP:**
  - Registered outputs are visible for exactly one cycle, then the FSM goes to IDLE unconditionally.
  - The mandatory IDLE cycle lets the fetch unit move `ibus_adr` after seeing the ack.
- **Error condition**, evaluated on `adr_r` at the RESP transition. Any one of:
  - `adr_r[1:0] != 0`;
  - `adr_r < MEM_BASE`;
  - `adr_r >= MEM_BASE + MEM_DEPTH*4`.
  - On error: `ibus_err_o=1`, `ibus_ack_o=0`, `ibus_dat_o=OPTION_RESET_INSN`.
  - Otherwise: `ibus_ack_o=1` and `ibus_dat_o = mem[(adr_r-MEM_BASE)>>2]`.
- **Read/write collision:** memory is read on the edge entering RESP. A load write to the same word on that same edge is not seen; the old data is returned.
- **Load port:** writes `mem[load_adr_i] <= load_dat_i` on any cycle, independent of FSM state.
- **Output hold:** `ibus_dat_o` keeps its last value outside RESP. `ibus_ack_o` and `ibus_err_o` are never both high.
- **Reset:** asynchronous `rst_n` low forces:
  - state IDLE, `cnt=0`, `adr_r=0`;
  - `ibus_ack_o=0`, `ibus_err_o=0`, `ibus_dat_o=OPTION_RESET_INSN`.
  - Memory contents are not reset. Reset mid-access discards the access with no pulse.

## Timing
- **Latency:** `ibus_req_i` sampled high in IDLE at edge T gives ack/err high during cycle T+1+WAIT_STATES, provided there are no freezes or restarts.
- **Freeze:** each frozen WAIT cycle adds one cycle of latency.
- **Restart:** an address change sampled at edge T' in WAIT gives a response in cycle T'+1+WAIT_STATES.
- **Throughput:** with `ibus_req_i` held high continuously, one pulse every WAIT_STATES+2 cycles.
- **Output registering:** all outputs are registered. There is no combinational path from any input to any output.
- **Address stability:** `ibus_adr_i` changing while in RESP does not affect the current response.

## Test plan
- **Reset:** `rst_n` low mid-WAIT → `ibus_ack_o=0`, `ibus_err_o=0`, `ibus_dat_o=32'h15000000` immediately. After release with req high, the first ack comes at T+1+WAIT_STATES.
- **Back-to-back fetch** (WAIT_STATES=1, mem[0..3]=32'hA0..A3, req held, adr stepping by 4 after each ack) → acks every 3 cycles carrying A0, A1, A2, A3 in order.
- **Errors:**
  - adr=MEM_BASE+MEM_DEPTH*4 → err pulse, dat=32'h15000000, no ack.
  - adr=0x2 → err pulse.
- **Abort and restart:**
  - req drops in WAIT → no pulse; FSM back in IDLE.
  - adr changes 0x0→0x8 in WAIT (WAIT_STATES=3) → single ack with mem[2], 4 cycles after the change.
- **Freeze:** WAIT_STATES=2 with `extra_wait_i` high for 3 WAIT cycles → ack at T+6.
- **Collision and zero-wait:**
  - load write of 32'hDEAD to mem[0] on the edge entering RESP for adr 0 → old value returned.
  - Next fetch of adr 0 → 32'hDEAD.
  - WAIT_STATES=0 → ack at T+1.
